// File: rtl/imem_loader.sv
// imem_loader: writer side of the byte-addressed instruction memory.
// Accepts a valid/ready byte stream and writes it big-endian from address 0,
// stalling the core while loading and zero-padding a partial final word.
// Optional feature macro: IMEM_CHECKSUM_EN (XOR checksum of written words).
module imem_loader #(
  parameter int WORD = 32,
  parameter int BYTE = 8,
  parameter int LINE = 42
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  input  logic [BYTE-1:0] in_byte,
  input  logic            in_last,
  output logic            in_ready,
  output logic            wr_en,
  output logic [WORD-1:0] wr_addr,
  output logic [BYTE-1:0] wr_data,
  output logic            cpu_stall,
  output logic            done,
  output logic            overflow,
  output logic [WORD-1:0] words,
  output logic [WORD-1:0] checksum
);

  localparam int PTR_W = $clog2(4 * LINE);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(4 * LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE-1:0]   wr_data_q, wr_data_d;
  logic              overflow_q, overflow_d;
  logic [WORD-1:0]   words_q, words_d;

  // Write request for this cycle; it becomes visible on the outputs next cycle.
  logic              wr_fire_s;
  logic [BYTE-1:0]   wr_byte_s;
  logic              reinit_s;

  // Next-state, pointer and write-port computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    overflow_d = overflow_q;
    words_d    = words_q;
    wr_fire_s  = 1'b0;
    wr_byte_s  = {BYTE{1'b0}};
    reinit_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          reinit_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_fire_s = 1'b1;
          wr_byte_s = in_byte;
          ptr_d     = ptr_q + PTR_W'(1);
          // Capacity reached or stream ends on a word boundary: finished.
          if ((ptr_q == LAST_PTR) || (in_last && (ptr_q[1:0] == 2'd3))) begin
            state_d = S_DONE;
          end else if (in_last) begin
            state_d = S_PAD;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_PAD: begin
        wr_fire_s = 1'b1;
        wr_byte_s = {BYTE{1'b0}};
        ptr_d     = ptr_q + PTR_W'(1);
        if (ptr_q[1:0] == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAD;
        end
      end
      S_DONE: begin
        // start wins over a simultaneous byte, which is simply not accepted.
        if (start) begin
          reinit_s = 1'b1;
        end else if (in_valid) begin
          overflow_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reinit_s) begin
      state_d    = S_LOAD;
      ptr_d      = {PTR_W{1'b0}};
      words_d    = {WORD{1'b0}};
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_d;
    end

    if (wr_fire_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = WORD'(ptr_q);
      wr_data_d = wr_byte_s;
      // Writing the last byte of a word completes that word.
      if (ptr_q[1:0] == 2'd3) begin
        words_d = words_q + WORD'(1);
      end else begin
        words_d = words_q;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // State, pointer and registered write-port flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= {PTR_W{1'b0}};
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {WORD{1'b0}};
      wr_data_q  <= {BYTE{1'b0}};
      overflow_q <= 1'b0;
      words_q    <= {WORD{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
      words_q    <= words_d;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [WORD-1:0]   csum_q, csum_d;
  logic [3*BYTE-1:0] asm_q, asm_d;

  // Fold one big-endian word {b0,b1,b2,b3} into the running XOR.
  function automatic logic [WORD-1:0] fold_word(input logic [WORD-1:0]   acc,
                                                input logic [3*BYTE-1:0] hi,
                                                input logic [BYTE-1:0]   lo);
    return acc ^ WORD'({hi, lo});
  endfunction

  // Word assembly and checksum update on each write.
  always_comb begin
    csum_d = csum_q;
    asm_d  = asm_q;
    if (reinit_s) begin
      csum_d = {WORD{1'b0}};
      asm_d  = {(3*BYTE){1'b0}};
    end else if (wr_fire_s) begin
      if (ptr_q[1:0] == 2'd3) begin
        csum_d = fold_word(csum_q, asm_q, wr_byte_s);
        asm_d  = {(3*BYTE){1'b0}};
      end else begin
        asm_d = {asm_q[2*BYTE-1:0], wr_byte_s};
      end
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum and assembly registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= {WORD{1'b0}};
      asm_q  <= {(3*BYTE){1'b0}};
    end else begin
      csum_q <= csum_d;
      asm_q  <= asm_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = {WORD{1'b0}};
`endif

  assign in_ready  = (state_q == S_LOAD);
  assign cpu_stall = (state_q == S_LOAD) || (state_q == S_PAD);
  assign done      = (state_q == S_DONE);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign overflow  = overflow_q;
  assign words     = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus hand-written corner sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [7:0]  in_byte;
  logic        in_ready, wr_en, cpu_stall, done, overflow;
  logic [31:0] wr_addr, words, checksum;
  logic [7:0]  wr_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_stall(cpu_stall), .done(done), .overflow(overflow),
    .words(words), .checksum(checksum)
  );

  typedef struct {
    logic        st, v;
    logic [7:0]  b;
    logic        l;
    logic        we;
    logic [31:0] wa;
    logic [7:0]  wd;
    logic        rdy, stall, dn, ovf;
    logic [31:0] w, cs;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [31:0] csx(input logic [31:0] x);
`ifdef IMEM_CHECKSUM_EN
    return x;
`else
    return 32'h0 & x;
`endif
  endfunction

  function automatic vec_t mk(input logic st, input logic v, input logic [7:0] b,
                              input logic l, input logic we, input logic [31:0] wa,
                              input logic [7:0] wd, input logic rdy, input logic stall,
                              input logic dn, input logic ovf, input logic [31:0] w,
                              input logic [31:0] cs);
    vec_t r;
    r.st = st; r.v = v; r.b = b; r.l = l; r.we = we; r.wa = wa; r.wd = wd;
    r.rdy = rdy; r.stall = stall; r.dn = dn; r.ovf = ovf; r.w = w; r.cs = csx(cs);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic v, input logic [7:0] b, input logic l);
    start = st; in_valid = v; in_byte = b; in_last = l;
  endtask

  task automatic chk_all(input string p, input logic we, input logic [31:0] wa,
                         input logic [7:0] wd, input logic rdy, input logic stall,
                         input logic dn, input logic ovf, input logic [31:0] w,
                         input logic [31:0] cs);
    chk({p, ".wr_en"},     64'(wr_en),     64'(we));
    chk({p, ".wr_addr"},   64'(wr_addr),   64'(wa));
    chk({p, ".wr_data"},   64'(wr_data),   64'(wd));
    chk({p, ".in_ready"},  64'(in_ready),  64'(rdy));
    chk({p, ".cpu_stall"}, 64'(cpu_stall), 64'(stall));
    chk({p, ".done"},      64'(done),      64'(dn));
    chk({p, ".overflow"},  64'(overflow),  64'(ovf));
    chk({p, ".words"},     64'(words),     64'(w));
    chk({p, ".checksum"},  64'(checksum),  64'(cs));
  endtask

  initial begin
    logic [31:0] acc;
    logic [31:0] wreg;

    //                st  v   b      l   we  wa  wd     rdy stl dn  ovf w  cs
    // Test 1: aligned 4-byte stream.
    tbl[0]  = mk(1'b1,1'b0,8'h00,1'b0, 1'b0,0, 8'h00, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[1]  = mk(1'b0,1'b1,8'h20,1'b0, 1'b1,0, 8'h20, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[2]  = mk(1'b0,1'b1,8'h08,1'b0, 1'b1,1, 8'h08, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[3]  = mk(1'b0,1'b1,8'h00,1'b0, 1'b1,2, 8'h00, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[4]  = mk(1'b0,1'b1,8'h05,1'b1, 1'b1,3, 8'h05, 1'b0,1'b0,1'b1,1'b0,1,32'h20080005);
    tbl[5]  = mk(1'b0,1'b0,8'h00,1'b0, 1'b0,3, 8'h05, 1'b0,1'b0,1'b1,1'b0,1,32'h20080005);
    // Test 2: partial word padded with zeros; byte offered during PAD ignored.
    tbl[6]  = mk(1'b1,1'b0,8'h00,1'b0, 1'b0,3, 8'h05, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[7]  = mk(1'b0,1'b1,8'hAA,1'b0, 1'b1,0, 8'hAA, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[8]  = mk(1'b0,1'b1,8'hBB,1'b1, 1'b1,1, 8'hBB, 1'b0,1'b1,1'b0,1'b0,0,32'h0);
    tbl[9]  = mk(1'b0,1'b1,8'hCC,1'b0, 1'b1,2, 8'h00, 1'b0,1'b1,1'b0,1'b0,0,32'h0);
    tbl[10] = mk(1'b0,1'b0,8'h00,1'b0, 1'b1,3, 8'h00, 1'b0,1'b0,1'b1,1'b0,1,32'hAABB0000);
    // Test 6: byte in DONE sets overflow; start+valid restarts and drops the byte.
    tbl[11] = mk(1'b0,1'b1,8'h77,1'b0, 1'b0,3, 8'h00, 1'b0,1'b0,1'b1,1'b1,1,32'hAABB0000);
    tbl[12] = mk(1'b1,1'b1,8'h99,1'b0, 1'b0,3, 8'h00, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    // Test 4: toggled valid; in_last without valid and start in LOAD ignored.
    tbl[13] = mk(1'b0,1'b1,8'h01,1'b0, 1'b1,0, 8'h01, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[14] = mk(1'b0,1'b0,8'h00,1'b0, 1'b0,0, 8'h01, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[15] = mk(1'b0,1'b1,8'h02,1'b0, 1'b1,1, 8'h02, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[16] = mk(1'b0,1'b0,8'h00,1'b1, 1'b0,1, 8'h02, 1'b1,1'b1,1'b0,1'b0,0,32'h0);
    tbl[17] = mk(1'b1,1'b0,8'h00,1'b0, 1'b0,1, 8'h02, 1'b1,1'b1,1'b0,1'b0,0,32'h0);

    // Reset state.
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk_all("reset", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    reset = 1'b0;

    // Table vectors.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].b, tbl[i].l);
      tick();
      chk_all($sformatf("v%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rdy,
              tbl[i].stall, tbl[i].dn, tbl[i].ovf, tbl[i].w, tbl[i].cs);
    end

    // Test 5: reset after 3 accepted bytes, then reload from address 0.
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
      tick();
    end
    chk("t5.third_write", {wr_en, wr_addr, wr_data}, {1'b1, 32'd2, 8'h42});
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'h44, 1'b0);
    tick();
    chk_all("t5.reset", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t5.idle%0d", i), {wr_en, in_ready, cpu_stall}, 3'b000);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h55, 1'b0);
    tick();
    chk("t5.reload", {wr_en, wr_addr, wr_data}, {1'b1, 32'd0, 8'h55});

    // Test 3: fill to capacity without in_last, then overflow.
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    acc  = 32'h0;
    wreg = 32'h0;
    for (int i = 0; i < 168; i++) begin
      drive(1'b0, 1'b1, 8'(i * 3 + 1), 1'b0);
      wreg = {wreg[23:0], 8'(i * 3 + 1)};
      if ((i % 4) == 3) acc = acc ^ wreg;
      tick();
      chk($sformatf("t3.wr%0d", i), {wr_en, wr_addr, wr_data}, {1'b1, 32'(i), 8'(i * 3 + 1)});
      if (i == 3) chk("t3.words1", 64'(words), 64'd1);
    end
    chk("t3.done", {done, in_ready, cpu_stall}, 3'b100);
    chk("t3.words", 64'(words), 64'd42);
    chk("t3.checksum", 64'(checksum), 64'(csx(acc)));
    drive(1'b0, 1'b1, 8'hEE, 1'b0);
    tick();
    chk("t3.overflow", {overflow, wr_en, done}, 3'b101);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t3.sticky", {overflow, wr_en, wr_addr}, {1'b1, 1'b0, 32'd167});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
